sdram_init_seq: RTL
===================

Name: sdram_init_seq

Overview:
- Parametrised SDRAM power-up/initialisation sequencer; successor to the fixed single-shot initialiser.
- Drives the SDRAM command bus from power-up until the device is ready: power-up wait, PRECHARGE ALL, N AUTO REFRESH, LOAD MODE REGISTER.
- Adds configurable timing, refresh count and mode-register fields, a runtime mode override, and re-initialisation without reset.
- Sits between the top level and the SDRAM pins; the read/write controller waits on ofin before owning the bus.

Parameters:
- T_PWR_CYC, 10000, power-up wait in iclk cycles (200 us at 50 MHz); >=1
- T_RP, 3, PRECHARGE-to-next-command cycles; >=1
- T_RFC, 7, AUTO REFRESH-to-next-command cycles; >=1
- T_MRD, 2, LOAD MODE-to-ready cycles; >=1
- N_REFRESH, 8, number of AUTO REFRESH commands; >=1
- CAS_LAT, 3, default mode A[6:4]
- BURST_LEN, 0, default mode A[2:0]
- BURST_TYPE, 0, default mode A[3]
- WB_MODE, 0, default mode A[9]
- PWRUP_ON_REINIT, 0, 1 = re-init also repeats the power-up wait
- ADDR_W, 13, DRAM_ADDR width
- DQ_W, 16, DRAM_DQ width

Ports:
- iclk  in  1  system clock
- ireset  in  1  synchronous, active-high reset
- ireq  in  1  start/re-init request, level-sampled
- ienb  in  1  enable; a request is accepted only when ienb=1
- imode_en  in  1  at acceptance, 1 = use imode instead of the parameter mode word
- imode  in  ADDR_W  override mode-register word
- ofin  out  1  init complete; held high until next acceptance or reset
- obusy  out  1  sequence in progress
- DRAM_CLK  out  1  equals iclk (pass-through)
- DRAM_CKE  out  1  clock enable
- DRAM_ADDR  out  ADDR_W  address/mode bus
- DRAM_BA  out  2  bank address
- DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  out  1 each  command
- DRAM_LDQM, DRAM_UDQM  out  1 each  byte masks
- DRAM_DQ  inout  DQ_W  always high-Z

Behaviour:
- Command encodings {CS,RAS,CAS,WE}:
  - INHIBIT = 1xxx, driven as 1111
  - NOP = 0111
  - PRECHARGE ALL = 0010 with ADDR[10]=1
  - AUTO REFRESH = 0001
  - LOAD MODE = 0000 with BA=0, ADDR=mode word
- Default mode word: {3'b0, WB_MODE, 2'b00, CAS_LAT[2:0], BURST_TYPE, BURST_LEN[2:0]}. Defaults give 13'h030.
- Reset and IDLE outputs: INHIBIT, CKE=0, ADDR=0, BA=0, DQM=11, DQ=Z, ofin=0, obusy=0.
- ireset has priority: state returns to IDLE at the next edge from any state, including mid-sequence.
- Acceptance: (ireq & ienb) sampled high at an edge while in IDLE or DONE.
  - Mode word is latched at that edge: imode if imode_en, else the default.
  - ofin clears and obusy sets at the same edge.
  - ireq is ignored while obusy=1.
  - Deasserting ienb mid-sequence has no effect; the sequence runs to completion.
- States and transitions:
  - IDLE: wait for acceptance. Next state is WAIT_PWR, or PRECH on a re-init from DONE when PWRUP_ON_REINIT=0.
  - WAIT_PWR: CKE=1, NOP for T_PWR_CYC cycles, then PRECH.
  - PRECH: one PRECHARGE ALL cycle, then T_RP-1 NOP cycles.
  - REF: one AUTO REFRESH cycle, then T_RFC-1 NOP cycles. Repeats N_REFRESH times using a refresh counter that wraps to 0 on exit.
  - LMR: one LOAD MODE cycle, then T_MRD-1 NOP cycles.
  - DONE: ofin=1, obusy=0, CKE=1, NOP driven, DQM=11.
- Each command is asserted for exactly one cycle; every non-command cycle while CKE=1 is NOP.
- Wait counter is a single down-counter sized for the largest of T_PWR_CYC, T_RP, T_RFC and T_MRD. When a T_x parameter is 1, there are no NOP cycles after that command.
- Latency from the acceptance edge to ofin high: T_PWR_CYC + T_RP + N_REFRESH*T_RFC + T_MRD cycles. For a re-init with PWRUP_ON_REINIT=0, omit the T_PWR_CYC term.
- CKE stays 1 through DONE and across re-init; it returns to 0 only on reset.

Test Plan:
- Params T_PWR_CYC=10, T_RP=2, N_REFRESH=2, T_RFC=4, T_MRD=2; reset, then ireq=ienb=1 -> required command sequence:
  - CKE rises 1 cycle after acceptance, then 10 NOP
  - PRECHARGE with A10=1, then 1 NOP
  - REF, 3 NOP, REF, 3 NOP
  - LOAD MODE with ADDR=13'h030, BA=0, then 1 NOP
  - ofin=1 exactly 22 cycles after acceptance
- ireq=1 with ienb=0 for 50 cycles -> stays IDLE: INHIBIT, CKE=0, ofin=0, obusy=0.
- imode_en=1, imode=13'h237 at acceptance; imode changed to 13'h000 mid-sequence -> LOAD MODE drives ADDR=13'h237.
- After DONE, pulse ireq with ienb=1 (PWRUP_ON_REINIT=0) -> ofin drops at the acceptance edge, sequence starts at PRECHARGE, ofin returns 12 cycles later, CKE never drops.
- Assert ireset during the second REF wait -> next edge: INHIBIT, CKE=0, ofin=0, obusy=0. A fresh request then runs the full 22-cycle sequence with the refresh count restarted at 0.
- Toggle ireq every cycle during a sequence -> command trace identical to the first scenario; no restart.

Source files
------------

// File: rtl/sdram_init_seq.sv
// rtl/sdram_init_seq.sv - SDRAM power-up / initialisation command sequencer
module sdram_init_seq #(
    parameter int T_PWR_CYC       = 10000,
    parameter int T_RP            = 3,
    parameter int T_RFC           = 7,
    parameter int T_MRD           = 2,
    parameter int N_REFRESH       = 8,
    parameter int CAS_LAT         = 3,
    parameter int BURST_LEN       = 0,
    parameter int BURST_TYPE      = 0,
    parameter int WB_MODE         = 0,
    parameter int PWRUP_ON_REINIT = 0,
    parameter int ADDR_W          = 13,
    parameter int DQ_W            = 16
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              ireq,
    input  logic              ienb,
    input  logic              imode_en,
    input  logic [ADDR_W-1:0] imode,
    output logic              ofin,
    output logic              obusy,
    output logic              DRAM_CLK,
    output logic              DRAM_CKE,
    output logic [ADDR_W-1:0] DRAM_ADDR,
    output logic [1:0]        DRAM_BA,
    output logic              DRAM_CS_N,
    output logic              DRAM_RAS_N,
    output logic              DRAM_CAS_N,
    output logic              DRAM_WE_N,
    output logic              DRAM_LDQM,
    output logic              DRAM_UDQM,
    inout  wire  [DQ_W-1:0]   DRAM_DQ
);

    // Wait counter must hold the longest interval minus one
    localparam int MAX_A = (T_PWR_CYC > T_RP)  ? T_PWR_CYC : T_RP;
    localparam int MAX_B = (T_RFC > T_MRD)     ? T_RFC     : T_MRD;
    localparam int MAX_T = (MAX_A > MAX_B)     ? MAX_A     : MAX_B;
    localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int REF_W = (N_REFRESH > 1) ? $clog2(N_REFRESH) : 1;

    localparam logic [CNT_W-1:0] C_PWR = CNT_W'(T_PWR_CYC - 1);
    localparam logic [CNT_W-1:0] C_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] C_RFC = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] C_MRD = CNT_W'(T_MRD - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(N_REFRESH - 1);

    localparam logic [12:0] DEF_MODE13 = {3'b000, 1'(WB_MODE), 2'b00, 3'(CAS_LAT),
                                          1'(BURST_TYPE), 3'(BURST_LEN)};
    localparam logic [ADDR_W-1:0] DEF_MODE = ADDR_W'(DEF_MODE13);
    localparam logic [ADDR_W-1:0] A10_MASK = ADDR_W'(1024);

    // Command encodings {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_PWR = 3'd1;
    localparam logic [2:0] S_PRECH    = 3'd2;
    localparam logic [2:0] S_REF      = 3'd3;
    localparam logic [2:0] S_LMR      = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [REF_W-1:0]  r_ref;
    logic [ADDR_W-1:0] r_mode;

    logic              w_accept;
    logic              w_cnt_zero;
    logic [3:0]        w_cmd;
    logic [ADDR_W-1:0] w_addr;
    logic              w_cke;

    assign w_accept   = ireq & ienb & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_cnt_zero = (r_cnt == '0);

    // Sequencer state, wait counter, refresh counter and latched mode word
    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ref   <= '0;
            r_mode  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_mode <= imode_en ? imode : DEF_MODE;
                        r_ref  <= '0;
                        if ((r_state == S_DONE) && (PWRUP_ON_REINIT == 0)) begin
                            r_state <= S_PRECH;
                            r_cnt   <= C_RP;
                        end else begin
                            r_state <= S_WAIT_PWR;
                            r_cnt   <= C_PWR;
                        end
                    end
                end
                S_WAIT_PWR: begin
                    if (w_cnt_zero) begin
                        r_state <= S_PRECH;
                        r_cnt   <= C_RP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_PRECH: begin
                    if (w_cnt_zero) begin
                        r_state <= S_REF;
                        r_cnt   <= C_RFC;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_REF: begin
                    if (w_cnt_zero) begin
                        if (r_ref == REF_LAST) begin
                            r_ref   <= '0;
                            r_state <= S_LMR;
                            r_cnt   <= C_MRD;
                        end else begin
                            r_ref <= r_ref + REF_W'(1);
                            r_cnt <= C_RFC;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_LMR: begin
                    if (w_cnt_zero) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Command decode: each command fires on the first cycle of its state (counter at reload value)
    always_comb begin
        w_cmd  = CMD_INHIBIT;
        w_addr = '0;
        w_cke  = 1'b0;
        case (r_state)
            S_WAIT_PWR, S_DONE: begin
                w_cke = 1'b1;
                w_cmd = CMD_NOP;
            end
            S_PRECH: begin
                w_cke = 1'b1;
                if (r_cnt == C_RP) begin
                    w_cmd  = CMD_PRE;
                    w_addr = A10_MASK;
                end else begin
                    w_cmd = CMD_NOP;
                end
            end
            S_REF: begin
                w_cke = 1'b1;
                w_cmd = (r_cnt == C_RFC) ? CMD_REF : CMD_NOP;
            end
            S_LMR: begin
                w_cke = 1'b1;
                if (r_cnt == C_MRD) begin
                    w_cmd  = CMD_LMR;
                    w_addr = r_mode;
                end else begin
                    w_cmd = CMD_NOP;
                end
            end
            default: begin
                w_cmd  = CMD_INHIBIT;
                w_addr = '0;
                w_cke  = 1'b0;
            end
        endcase
    end

    assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = w_cmd;
    assign DRAM_ADDR = w_addr;
    assign DRAM_CKE  = w_cke;
    assign DRAM_BA   = 2'b00;
    assign DRAM_LDQM = 1'b1;
    assign DRAM_UDQM = 1'b1;
    assign DRAM_CLK  = iclk;
    assign DRAM_DQ   = {DQ_W{1'bz}};

    assign ofin  = (r_state == S_DONE);
    assign obusy = (r_state == S_WAIT_PWR) | (r_state == S_PRECH) |
                   (r_state == S_REF)      | (r_state == S_LMR);

endmodule
